// File: rtl/spike_frame_counter_pkg.sv
// Shared types for the spike frame counter slice: the FIFO entry layout,
// the frame FSM encoding and the drop-counter width.
package spike_pkg;

  localparam int DROP_W    = 8;
  // Storage width of a FIFO entry count; instances use the low CNT_W bits.
  localparam int CNT_MAX_W = 16;

  typedef struct packed {
    logic                 ovf;
    logic [CNT_MAX_W-1:0] count;
  } frame_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frame_state_e;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/spike_frame_counter_if.sv
// Valid/ready readout channel carrying one per-frame spike count.
// master: the counter (drives data/valid); slave: the readout consumer.
interface spike_frame_counter_if #(
  parameter int CNT_W = 8
) ();

  logic [CNT_W-1:0] count_data;
  logic             count_ovf;
  logic             count_valid;
  logic             count_ready;

  modport master (
    output count_data,
    output count_ovf,
    output count_valid,
    input  count_ready
  );

  modport slave (
    input  count_data,
    input  count_ovf,
    input  count_valid,
    output count_ready
  );

endinterface

// File: rtl/spike_frame_counter_fifo.sv
// Small synchronous FIFO of completed-frame entries. A push while full is
// accepted only when a pop happens on the same edge (pop applied first).
module spike_frame_fifo
  import spike_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  frame_entry_t din,
  input  logic         pop,
  output frame_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  frame_entry_t    mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            push_ok;
  logic            pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values from accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spike_frame_counter.sv
// Spike frame counter: captures single-phase spikes on the falling edge,
// counts them over frames of FRAME_LEN enabled cycles and queues one count
// per frame for the readout.
// Build option: SPIKE_CNT_SAT_EN -> counts saturate on overflow instead of
// wrapping; the ovf flag is set and sticky for the frame either way.
//
//   state | meaning
//   IDLE  | en low: accumulator and frame position held (frame paused)
//   RUN   | en high: count captured spikes, advance frame position
module spike_frame_counter
  import spike_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  spike_in,
  spike_frame_counter_if.master cnt_if,
  output logic                  frame_done,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int              PW      = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0]   LAST    = PW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [0:0]      S_IDLE  = IDLE;
  localparam logic [0:0]      S_RUN   = RUN;

  logic               cap_q;
  logic [0:0]         state;
  logic [CNT_W-1:0]   acc_q, acc_d, acc_sum;
  logic [PW-1:0]      pos_q, pos_d;
  logic               ovf_q, ovf_d, ovf_now;
  logic               close;
  frame_entry_t       close_entry;
  logic               push_q;
  frame_entry_t       push_entry_q;
  logic               frame_done_q;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               pop;
  logic               fifo_full, fifo_empty;
  frame_entry_t       head;
  logic               unused_head_bits;

  // Spike capture on the falling edge, ahead of the spikifier's own clear.
  always_ff @(negedge clk) begin
    if (rst) cap_q <= 1'b0;
    else     cap_q <= spike_in;
  end

  assign state = en ? S_RUN : S_IDLE;
  assign close = (state == S_RUN) && (pos_q == LAST);

  // Accumulate the captured bit, flagging and handling overflow.
  always_comb begin
    ovf_now = cap_q && (acc_q == CNT_MAX);
`ifdef SPIKE_CNT_SAT_EN
    acc_sum = ovf_now ? acc_q : acc_q + CNT_W'(cap_q);
`else
    acc_sum = acc_q + CNT_W'(cap_q);
`endif
    close_entry       = '0;
    close_entry.ovf   = ovf_q | ovf_now;
    close_entry.count = CNT_MAX_W'(acc_sum);
  end

  // Frame progression: advance in RUN, restart the frame on close.
  always_comb begin
    acc_d = acc_q;
    pos_d = pos_q;
    ovf_d = ovf_q;
    if (state == S_RUN) begin
      if (close) begin
        acc_d = '0;
        pos_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum;
        pos_d = pos_q + 1'b1;
        ovf_d = ovf_q | ovf_now;
      end
    end
  end

  // Frame state registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      pos_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pos_q <= pos_d;
      ovf_q <= ovf_d;
    end
  end

  // The closed frame is staged one cycle before entering the FIFO, so valid
  // follows frame_done by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q       <= 1'b0;
      push_entry_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      push_q       <= close;
      push_entry_q <= close ? close_entry : push_entry_q;
      frame_done_q <= close;
    end
  end

  assign pop = cnt_if.count_valid && cnt_if.count_ready;

  // A staged frame is lost only when the FIFO is full and nothing pops.
  always_comb begin
    drop_d = drop_q;
    if (push_q && fifo_full && !pop) drop_d = drop_inc(drop_q);
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  spike_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (push_entry_q),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is forced to zero while empty so outputs are clean out of reset.
  assign cnt_if.count_valid = !fifo_empty;
  assign cnt_if.count_data  = fifo_empty ? '0 : head.count[CNT_W-1:0];
  assign cnt_if.count_ovf   = !fifo_empty && head.ovf;
  assign frame_done         = frame_done_q;
  assign drop_cnt           = drop_q;

  // Upper storage bits above CNT_W are always zero.
  assign unused_head_bits = ^head.count;

endmodule

// File: tb/tb_spike_frame_counter.sv
// Bench for spike_frame_counter: two instances (8-bit/8-cycle/depth-2 and
// 3-bit/12-cycle/depth-4) driven with the same stimulus and compared every
// cycle against a frame-level reference model.
module tb_spike_frame_counter;
  import spike_pkg::*;

`ifdef SPIKE_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, spike_in, ready;
  logic fd0, fd1;
  logic [DROP_W-1:0] dc0, dc1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_frame_counter_if #(.CNT_W(8)) if0 ();
  spike_frame_counter_if #(.CNT_W(3)) if1 ();
  assign if0.count_ready = ready;
  assign if1.count_ready = ready;

  spike_frame_counter #(.CNT_W(8), .FRAME_LEN(8), .FIFO_DEPTH(2)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cnt_if(if0), .frame_done(fd0), .drop_cnt(dc0));

  spike_frame_counter #(.CNT_W(3), .FRAME_LEN(12), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
    .cnt_if(if1), .frame_done(fd1), .drop_cnt(dc1));

  // Reference model: spikes and enabled cycles per frame, pending frame,
  // ordered list of queued counts.
  int m_spk  [2];
  int m_cyc  [2];
  int m_drop [2];
  int m_size [2];
  bit m_pend [2];
  int m_pcnt [2];
  bit m_povf [2];
  bit m_fd   [2];
  int q_cnt  [2][4];
  bit q_ovf  [2][4];

  function automatic int frame_len(input int i); return (i == 0) ? 8 : 12; endfunction
  function automatic int max_cnt(input int i);   return (i == 0) ? 255 : 7; endfunction
  function automatic int depth(input int i);     return (i == 0) ? 2 : 4; endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_spk[i] = 0; m_cyc[i] = 0; m_drop[i] = 0; m_size[i] = 0;
      m_pend[i] = 1'b0; m_pcnt[i] = 0; m_povf[i] = 1'b0; m_fd[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input bit e, input bit s, input bit r);
    for (int i = 0; i < 2; i++) begin
      if (m_size[i] > 0 && r) begin
        for (int j = 0; j < 3; j++) begin
          q_cnt[i][j] = q_cnt[i][j+1];
          q_ovf[i][j] = q_ovf[i][j+1];
        end
        m_size[i]--;
      end
      if (m_pend[i]) begin
        if (m_size[i] < depth(i)) begin
          q_cnt[i][m_size[i]] = m_pcnt[i];
          q_ovf[i][m_size[i]] = m_povf[i];
          m_size[i]++;
        end else if (m_drop[i] < 255) begin
          m_drop[i]++;
        end
        m_pend[i] = 1'b0;
      end
      m_fd[i] = 1'b0;
      if (e) begin
        m_spk[i] += int'(s);
        m_cyc[i]++;
        if (m_cyc[i] == frame_len(i)) begin
          m_povf[i] = (m_spk[i] > max_cnt(i));
          if (!m_povf[i])  m_pcnt[i] = m_spk[i];
          else if (SAT)    m_pcnt[i] = max_cnt(i);
          else             m_pcnt[i] = m_spk[i] % (max_cnt(i) + 1);
          m_pend[i] = 1'b1;
          m_fd[i]   = 1'b1;
          m_spk[i]  = 0;
          m_cyc[i]  = 0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".valid0"}, 32'(if0.count_valid), 32'(m_size[0] != 0));
    if (m_size[0] != 0) begin
      chk({ph, ".data0"}, 32'(if0.count_data), q_cnt[0][0]);
      chk({ph, ".ovf0"},  32'(if0.count_ovf),  32'(q_ovf[0][0]));
    end
    chk({ph, ".done0"}, 32'(fd0), 32'(m_fd[0]));
    chk({ph, ".drop0"}, 32'(dc0), m_drop[0]);
    chk({ph, ".valid1"}, 32'(if1.count_valid), 32'(m_size[1] != 0));
    if (m_size[1] != 0) begin
      chk({ph, ".data1"}, 32'(if1.count_data), q_cnt[1][0]);
      chk({ph, ".ovf1"},  32'(if1.count_ovf),  32'(q_ovf[1][0]));
    end
    chk({ph, ".done1"}, 32'(fd1), 32'(m_fd[1]));
    chk({ph, ".drop1"}, 32'(dc1), m_drop[1]);
  endtask

  // One clock: inputs set just after posedge, spike cleared after the
  // falling-edge capture, outputs checked 1 ns after the next posedge.
  task automatic step(input bit e, input bit s, input bit r, input string ph);
    rst = 1'b0; en = e; spike_in = s; ready = r;
    @(negedge clk);
    #1 spike_in = 1'b0;
    @(posedge clk);
    model_edge(e, s, r);
    #1 check_all(ph);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; spike_in = 1'b0;
    @(posedge clk);
    model_reset();
    #1 check_all("rst");
    chk("rst.data0", 32'(if0.count_data), 0);
    chk("rst.ovf0",  32'(if0.count_ovf),  0);
    chk("rst.data1", 32'(if1.count_data), 0);
    chk("rst.ovf1",  32'(if1.count_ovf),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; spike_in = 1'b0; ready = 1'b0;
    do_reset();
    do_reset();

    // Spike every enabled cycle: 8 per frame on dut0, overflow on dut1.
    repeat (24) step(1'b1, 1'b1, 1'b1, "allspk");

    // Spikes at frame positions 0, 3 and 7 only; the last one must count.
    for (int i = 0; i < 9; i++)
      step(1'b1, (i == 0 || i == 3 || i == 7), 1'b1, "sparse");
    chk("sparse.valid0", 32'(if0.count_valid), 1);
    chk("sparse.cnt0",   32'(if0.count_data),  3);
    step(1'b1, 1'b0, 1'b1, "sparse");

    // Pause mid-frame with spikes present; they must be ignored.
    repeat (3)  step(1'b1, 1'($urandom_range(0, 1)), 1'b1, "pause");
    repeat (5)  step(1'b0, 1'b1, 1'b1, "pause");
    repeat (20) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, "pause");

    // Backpressure long enough to fill both FIFOs and drop frames.
    repeat (40) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, "stall");
    repeat (24) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, "drain");

    // Random mix of enable, spikes and ready.
    repeat (400) step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), "rand");

    // Queue entries, stop mid-frame, reset, then count a fresh frame.
    repeat (40) step(1'b1, 1'b1, 1'b0, "fill");
    do_reset();
    chk("postrst.valid1", 32'(if1.count_valid), 0);
    chk("postrst.drop0",  32'(dc0), 0);
    repeat (10) step(1'b1, 1'b1, 1'b1, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
